fetch_decode_execute: RTL and testbench

Front end of the CPU pipeline. It holds the instruction memory, which is loaded from UART bytes. It fetches the word at an externally generated PC, decodes it, and performs ALU and branch resolution on operands returned by the external register file. It sits between the PC generator/write-back stage (which supplies `pc_in` and `pc1_in`) and memory access (which consumes the registered EX outputs).

---
 rtl/fetch_decode_execute.sv | 219 +++++++++++++++++++++
 tb/tb_fetch_decode_execute.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_execute.sv
// CPU front end: UART-loaded instruction memory, IF register, and a registered
// decode/execute stage that resolves ALU results and branches.
module fetch_decode_execute #(
    parameter int INST_MEM_WIDTH = 2
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [INST_MEM_WIDTH-1:0] pc_in,
    input  logic [INST_MEM_WIDTH-1:0] pc1_in,
    input  logic                      flush,
    input  logic [7:0]                input_data,
    input  logic                      input_valid,
    input  logic                      input_start,
    input  logic                      input_end,
    output logic [4:0]                rs,
    output logic [4:0]                rt,
    input  logic [31:0]               op1,
    input  logic [31:0]               op2,
    output logic                      ex_bubble,
    output logic                      RegWrite,
    output logic                      MemWrite,
    output logic                      MemRead,
    output logic                      UARTtoReg,
    output logic                      RegtoUART,
    output logic [1:0]                MemtoReg,
    output logic [1:0]                Branch,
    output logic [31:0]               alu_result,
    output logic [31:0]               register_data,
    output logic [4:0]                rdist,
    output logic [25:0]               inst_index,
    output logic [INST_MEM_WIDTH-1:0] pc_out,
    output logic [INST_MEM_WIDTH-1:0] pc1_out,
    output logic [INST_MEM_WIDTH-1:0] pc2_out,
    output logic                      loading
);

    localparam int DEPTH = 1 << INST_MEM_WIDTH;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                           OP_LUI   = 6'h0F, OP_IN   = 6'h1C, OP_OUT  = 6'h1D,
                           OP_LW    = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08,
                           FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_SLT = 6'h2A;

    logic [31:0]               imem [DEPTH];
    logic [INST_MEM_WIDTH-1:0] wr_ptr;
    logic [1:0]                byte_cnt;
    logic [23:0]               byte_acc;
    logic                      imem_we;

    // Loader: end beats start, and the 4th byte of a word commits it.
    assign imem_we = !reset && loading && !input_end && input_valid && (byte_cnt == 2'd3);

    always_ff @(posedge CLK) begin
        if (reset) begin
            loading  <= 1'b0;
            wr_ptr   <= '0;
            byte_cnt <= 2'd0;
        end else if (input_end) begin
            loading <= 1'b0;
        end else if (input_start && !loading) begin
            loading  <= 1'b1;
            wr_ptr   <= '0;
            byte_cnt <= 2'd0;
        end else if (loading && input_valid) begin
            byte_acc <= {byte_acc[15:0], input_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3)
                wr_ptr <= wr_ptr + INST_MEM_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (imem_we)
            imem[wr_ptr] <= {byte_acc, input_data};
    end

    // ---- IF stage register ----
    logic                      if_bubble_p0;
    logic [31:0]               if_inst_p0;
    logic [INST_MEM_WIDTH-1:0] if_pc_p0;
    logic [INST_MEM_WIDTH-1:0] if_pc1_p0;

    always_ff @(posedge CLK) begin
        if (reset) begin
            if_bubble_p0 <= 1'b1;
            if_inst_p0   <= '0;
            if_pc_p0     <= '0;
            if_pc1_p0    <= '0;
        end else begin
            if_bubble_p0 <= flush | loading;
            if_inst_p0   <= imem[pc_in];
            if_pc_p0     <= pc_in;
            if_pc1_p0    <= pc1_in;
        end
    end

    assign rs = if_inst_p0[25:21];
    assign rt = if_inst_p0[20:16];

    // ---- decode / execute (combinational) ----
    logic [5:0]         opcode, funct;
    logic [4:0]         rd, sa;
    logic signed [31:0] op1_s, op2_s, sext_imm;
    logic [31:0]        zext_imm;

    assign opcode   = if_inst_p0[31:26];
    assign funct    = if_inst_p0[5:0];
    assign rd       = if_inst_p0[15:11];
    assign sa       = if_inst_p0[10:6];
    assign op1_s    = op1;
    assign op2_s    = op2;
    assign sext_imm = {{16{if_inst_p0[15]}}, if_inst_p0[15:0]};
    assign zext_imm = {16'h0000, if_inst_p0[15:0]};

    logic        d_regwrite, d_memwrite, d_memread, d_uart2reg, d_reg2uart;
    logic [1:0]  d_memtoreg, d_branch;
    logic [31:0] d_alu, d_rdata;
    logic [4:0]  d_rdist;

    always_comb begin
        d_regwrite = 1'b0;
        d_memwrite = 1'b0;
        d_memread  = 1'b0;
        d_uart2reg = 1'b0;
        d_reg2uart = 1'b0;
        d_memtoreg = 2'd0;
        d_branch   = 2'd0;
        d_alu      = '0;
        d_rdata    = op2;
        d_rdist    = rt;
        case (opcode)
            OP_RTYPE: begin
                d_rdist    = rd;
                d_regwrite = 1'b1;
                case (funct)
                    FN_ADD: d_alu = op1 + op2;
                    FN_SUB: d_alu = op1 - op2;
                    FN_AND: d_alu = op1 & op2;
                    FN_OR:  d_alu = op1 | op2;
                    FN_SLT: d_alu = (op1_s < op2_s) ? 32'd1 : 32'd0;
                    FN_SLL: d_alu = op2 << sa;
                    FN_SRL: d_alu = op2 >> sa;
                    FN_JR: begin
                        d_regwrite = 1'b0;
                        d_branch   = 2'd3;
                        d_alu      = op1;
                    end
                    default: d_regwrite = 1'b0;
                endcase
            end
            OP_ADDI: begin d_regwrite = 1'b1; d_alu = op1 + sext_imm; end
            OP_SLTI: begin d_regwrite = 1'b1; d_alu = (op1_s < sext_imm) ? 32'd1 : 32'd0; end
            OP_ANDI: begin d_regwrite = 1'b1; d_alu = op1 & zext_imm; end
            OP_ORI:  begin d_regwrite = 1'b1; d_alu = op1 | zext_imm; end
            OP_LUI:  begin d_regwrite = 1'b1; d_alu = {if_inst_p0[15:0], 16'h0000}; end
            OP_LW: begin
                d_regwrite = 1'b1;
                d_memread  = 1'b1;
                d_memtoreg = 2'd1;
                d_alu      = op1 + sext_imm;
            end
            OP_SW: begin d_memwrite = 1'b1; d_alu = op1 + sext_imm; end
            OP_BEQ:  d_branch = (op1 == op2) ? 2'd1 : 2'd0;
            OP_BNE:  d_branch = (op1 != op2) ? 2'd1 : 2'd0;
            OP_J:    d_branch = 2'd2;
            OP_JAL: begin
                d_branch   = 2'd2;
                d_regwrite = 1'b1;
                d_memtoreg = 2'd2;
                d_rdist    = 5'd31;
            end
            OP_IN:  begin d_uart2reg = 1'b1; d_regwrite = 1'b1; end
            OP_OUT: begin d_reg2uart = 1'b1; d_rdata = op1; end
            default: ;
        endcase
    end

    // ---- EX stage register ----
    always_ff @(posedge CLK) begin
        if (reset) begin
            ex_bubble     <= 1'b1;
            RegWrite      <= 1'b0;
            MemWrite      <= 1'b0;
            MemRead       <= 1'b0;
            UARTtoReg     <= 1'b0;
            RegtoUART     <= 1'b0;
            MemtoReg      <= 2'd0;
            Branch        <= 2'd0;
            alu_result    <= '0;
            register_data <= '0;
            rdist         <= '0;
            inst_index    <= '0;
            pc_out        <= '0;
            pc1_out       <= '0;
            pc2_out       <= '0;
        end else begin
            ex_bubble     <= if_bubble_p0;
            RegWrite      <= d_regwrite & ~if_bubble_p0;
            MemWrite      <= d_memwrite & ~if_bubble_p0;
            MemRead       <= d_memread & ~if_bubble_p0;
            UARTtoReg     <= d_uart2reg & ~if_bubble_p0;
            RegtoUART     <= d_reg2uart & ~if_bubble_p0;
            MemtoReg      <= d_memtoreg;
            Branch        <= if_bubble_p0 ? 2'd0 : d_branch;
            alu_result    <= d_alu;
            register_data <= d_rdata;
            rdist         <= d_rdist;
            inst_index    <= if_inst_p0[25:0];
            pc_out        <= if_pc_p0;
            pc1_out       <= if_pc1_p0;
            pc2_out       <= if_pc1_p0 + sext_imm[INST_MEM_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Self-checking bench for fetch_decode_execute: directed scenarios plus a
// randomized pipelined run checked against an instruction-level model.
module tb_fetch_decode_execute;

    localparam int N = 2;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  pc_in = '0, pc1_in = '0;
    logic          flush = 1'b0;
    logic [7:0]    input_data = '0;
    logic          input_valid = 1'b0, input_start = 1'b0, input_end = 1'b0;
    logic [4:0]    rs, rt;
    logic [31:0]   op1 = '0, op2 = '0;
    logic          ex_bubble, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART;
    logic [1:0]    MemtoReg, Branch;
    logic [31:0]   alu_result, register_data;
    logic [4:0]    rdist;
    logic [25:0]   inst_index;
    logic [N-1:0]  pc_out, pc1_out, pc2_out;
    logic          loading;

    fetch_decode_execute #(.INST_MEM_WIDTH(N)) dut (
        .CLK(CLK), .reset(reset), .pc_in(pc_in), .pc1_in(pc1_in), .flush(flush),
        .input_data(input_data), .input_valid(input_valid),
        .input_start(input_start), .input_end(input_end),
        .rs(rs), .rt(rt), .op1(op1), .op2(op2),
        .ex_bubble(ex_bubble), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemRead(MemRead), .UARTtoReg(UARTtoReg), .RegtoUART(RegtoUART),
        .MemtoReg(MemtoReg), .Branch(Branch), .alu_result(alu_result),
        .register_data(register_data), .rdist(rdist), .inst_index(inst_index),
        .pc_out(pc_out), .pc1_out(pc1_out), .pc2_out(pc2_out), .loading(loading)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;

    logic [31:0] mm [4];
    int          mptr = 0;
    logic [4:0]  obs_rs, obs_rt;

    typedef struct packed {
        logic        rw, mw, mr, u2r, r2u;
        logic [1:0]  mtr, br;
        logic [31:0] alu;
        logic        alu_c;
        logic [31:0] rdat;
        logic [4:0]  rdist;
        logic [N-1:0] pc2;
        logic        pc2_c;
    } exp_t;

    // Instruction-level reference: what the ISA says each instruction produces.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] a,
                                   input logic [31:0] b, input int pc1);
        exp_t e;
        int op, fn, sh, ia, ib, simm;
        logic [31:0] zimm;
        op = int'(inst[31:26]); fn = int'(inst[5:0]); sh = int'(inst[10:6]);
        ia = int'(a); ib = int'(b);
        simm = int'($signed(inst[15:0]));
        zimm = {16'h0, inst[15:0]};
        e = '0;
        e.rdat = b;
        e.rdist = inst[20:16];
        if (op == 0) begin
            e.rdist = inst[15:11];
            e.alu_c = 1'b1;
            e.rw = 1'b1;
            if      (fn == 32) e.alu = a + b;
            else if (fn == 34) e.alu = a - b;
            else if (fn == 36) e.alu = a & b;
            else if (fn == 37) e.alu = a | b;
            else if (fn == 42) e.alu = (ia < ib) ? 1 : 0;
            else if (fn == 0)  e.alu = b << sh;
            else if (fn == 2)  e.alu = b >> sh;
            else if (fn == 8)  begin e.rw = 0; e.br = 3; e.alu = a; end
            else begin e.rw = 0; e.alu_c = 0; end
        end else if (op == 8)  begin e.rw = 1; e.alu_c = 1; e.alu = 32'(ia + simm); end
        else if (op == 10) begin e.rw = 1; e.alu_c = 1; e.alu = (ia < simm) ? 1 : 0; end
        else if (op == 12) begin e.rw = 1; e.alu_c = 1; e.alu = a & zimm; end
        else if (op == 13) begin e.rw = 1; e.alu_c = 1; e.alu = a | zimm; end
        else if (op == 15) begin e.rw = 1; e.alu_c = 1; e.alu = zimm * 65536; end
        else if (op == 35) begin e.rw = 1; e.mr = 1; e.mtr = 1; e.alu_c = 1; e.alu = 32'(ia + simm); end
        else if (op == 43) begin e.mw = 1; e.alu_c = 1; e.alu = 32'(ia + simm); end
        else if (op == 4 || op == 5) begin
            e.br = ((a == b) == (op == 4)) ? 2'd1 : 2'd0;
            e.pc2_c = 1'b1;
            e.pc2 = N'((pc1 + simm) & ((1 << N) - 1));
        end
        else if (op == 2)  e.br = 2;
        else if (op == 3)  begin e.br = 2; e.rw = 1; e.mtr = 2; e.rdist = 31; end
        else if (op == 28) begin e.u2r = 1; e.rw = 1; end
        else if (op == 29) begin e.r2u = 1; e.rdat = a; end
        return e;
    endfunction

    task automatic load_start();
        @(negedge CLK); input_start = 1'b1;
        @(negedge CLK); input_start = 1'b0;
        mptr = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK); input_data = b; input_valid = 1'b1;
        @(negedge CLK); input_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit in_load);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
        if (in_load) begin
            mm[mptr] = w;
            mptr = (mptr + 1) % 4;
        end
    endtask

    task automatic load_end();
        @(negedge CLK); input_end = 1'b1;
        @(negedge CLK); input_end = 1'b0;
    endtask

    // Fetch pc, feed operands once rs/rt are visible, return with EX outputs valid.
    task automatic fetch_exec(input int pc, input int pc1, input logic [31:0] a,
                              input logic [31:0] b, input bit fl);
        @(negedge CLK); pc_in = N'(pc); pc1_in = N'(pc1); flush = fl;
        @(negedge CLK); flush = 1'b0; obs_rs = rs; obs_rt = rt; op1 = a; op2 = b;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK); reset = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({ex_bubble, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART} !== 6'b100000)
            $display("FAIL reset_ctrl got=%b want=100000",
                     {ex_bubble, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART});
        else passed++;
        checks++;
        if (Branch !== 2'd0) $display("FAIL reset_branch got=%0d want=0", Branch); else passed++;
        checks++;
        if (loading !== 1'b0) $display("FAIL reset_loading got=%b want=0", loading); else passed++;
        checks++;
        if ({alu_result, register_data, pc_out, pc2_out} !== '0)
            $display("FAIL reset_data got=%h/%h/%0d/%0d want=0", alu_result, register_data, pc_out, pc2_out);
        else passed++;
        checks++;
        if ({rs, rt} !== 10'd0) $display("FAIL reset_rsrt got=%0d/%0d want=0/0", rs, rt); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_load_addi();
        load_start();
        checks++;
        if (loading !== 1'b1) $display("FAIL load_entry got=%b want=1", loading); else passed++;
        send_word(32'h20010005, 1'b1);
        send_word(32'h00221820, 1'b1);
        send_word(32'h1021FFFF, 1'b1);
        send_word(32'h0C000002, 1'b1);
        load_end();
        checks++;
        if (loading !== 1'b0) $display("FAIL load_exit got=%b want=0", loading); else passed++;
        fetch_exec(0, 1, 32'd0, 32'd0, 1'b0);
        checks++;
        if (RegWrite !== 1'b1 || ex_bubble !== 1'b0)
            $display("FAIL addi_ctrl got=%b%b want=10", RegWrite, ex_bubble);
        else passed++;
        checks++;
        if (rdist !== 5'd1 || alu_result !== 32'd5 || pc_out !== 2'd0)
            $display("FAIL addi_data got=%0d/%0d/%0d want=1/5/0", rdist, alu_result, pc_out);
        else passed++;
    endtask

    task automatic test_add();
        fetch_exec(1, 2, 32'd7, 32'hFFFFFFFD, 1'b0);
        checks++;
        if (obs_rs !== 5'd1 || obs_rt !== 5'd2)
            $display("FAIL add_rsrt got=%0d/%0d want=1/2", obs_rs, obs_rt);
        else passed++;
        checks++;
        if (alu_result !== 32'd4 || rdist !== 5'd3 || RegWrite !== 1'b1)
            $display("FAIL add_result got=%0d/%0d/%b want=4/3/1", alu_result, rdist, RegWrite);
        else passed++;
    endtask

    task automatic test_branch();
        fetch_exec(2, 1, 32'd9, 32'd9, 1'b0);
        checks++;
        if (Branch !== 2'd1 || pc2_out !== 2'd0)
            $display("FAIL beq_taken got=%0d/%0d want=1/0", Branch, pc2_out);
        else passed++;
        fetch_exec(2, 1, 32'd9, 32'd8, 1'b0);
        checks++;
        if (Branch !== 2'd0) $display("FAIL beq_not_taken got=%0d want=0", Branch); else passed++;
    endtask

    task automatic test_jal();
        fetch_exec(3, 0, 32'd0, 32'd0, 1'b0);
        checks++;
        if (Branch !== 2'd2 || RegWrite !== 1'b1 || MemtoReg !== 2'd2)
            $display("FAIL jal_ctrl got=%0d/%b/%0d want=2/1/2", Branch, RegWrite, MemtoReg);
        else passed++;
        checks++;
        if (rdist !== 5'd31 || inst_index !== 26'd2)
            $display("FAIL jal_data got=%0d/%0d want=31/2", rdist, inst_index);
        else passed++;
    endtask

    task automatic test_slt_flush_bad();
        load_start();
        send_word(32'h0022182A, 1'b1);
        send_word(32'hFC000000, 1'b1);
        load_end();
        fetch_exec(0, 0, 32'hFFFFFFFF, 32'd1, 1'b0);
        checks++;
        if (alu_result !== 32'd1) $display("FAIL slt got=%0d want=1", alu_result); else passed++;
        fetch_exec(0, 0, 32'hFFFFFFFF, 32'd1, 1'b1);
        checks++;
        if ({ex_bubble, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART, Branch} !== 8'b10000000)
            $display("FAIL flush got=%b want=10000000",
                     {ex_bubble, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART, Branch});
        else passed++;
        fetch_exec(1, 0, 32'd3, 32'd3, 1'b0);
        checks++;
        if ({ex_bubble, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART, Branch} !== 8'b00000000)
            $display("FAIL bad_opcode got=%b want=00000000",
                     {ex_bubble, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART, Branch});
        else passed++;
    endtask

    // Partial word discarded, idle bytes ignored, reset aborts a load but keeps memory.
    task automatic test_load_edges();
        logic [31:0] old2;
        old2 = mm[2];
        send_word(32'h3C01ABCD, 1'b0);
        load_start();
        send_word(32'h3401BEEF, 1'b1);
        send_word(32'h20020007, 1'b1);
        send_byte(8'h24); send_byte(8'h03);
        load_end();
        fetch_exec(2, 0, 32'd0, 32'd0, 1'b0);
        checks++;
        if (inst_index !== old2[25:0])
            $display("FAIL partial_discard got=%h want=%h", inst_index, old2[25:0]);
        else passed++;
        fetch_exec(0, 0, 32'h00010000, 32'd0, 1'b0);
        checks++;
        if (alu_result !== 32'h0001BEEF)
            $display("FAIL idle_bytes_ignored got=%h want=0001beef", alu_result);
        else passed++;
        load_start();
        send_word(32'h2004FFFF, 1'b1);
        send_byte(8'h11);
        @(negedge CLK); reset = 1'b1;
        @(negedge CLK); reset = 1'b0;
        checks++;
        if (loading !== 1'b0) $display("FAIL reset_midload got=%b want=0", loading); else passed++;
        fetch_exec(0, 0, 32'd1, 32'd0, 1'b0);
        checks++;
        if (alu_result !== 32'd0 || rdist !== 5'd4)
            $display("FAIL midload_kept got=%h/%0d want=0/4", alu_result, rdist);
        else passed++;
        fetch_exec(1, 0, 32'd1, 32'd0, 1'b0);
        checks++;
        if (alu_result !== 32'd8) $display("FAIL midload_next got=%h want=8", alu_result); else passed++;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops [15];
        logic [5:0] fns [9];
        logic [5:0] op;
        logic [31:0] body;
        ops = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23,
                6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h1C, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08, 6'h3F};
        op = ops[$urandom_range(0, 14)];
        if ($urandom_range(0, 15) == 0) op = 6'h1D;
        body = $urandom;
        if (op == 6'h00) body[5:0] = fns[$urandom_range(0, 8)];
        return {op, body[25:0]};
    endfunction

    task automatic test_back_to_back();
        bit          have_if, have_ex, if_bub, ex_bub;
        logic [31:0] if_inst, ex_inst, a, b;
        int          if_pc, if_pc1, ex_pc, ex_pc1, pc;
        exp_t        e;
        for (int r = 0; r < 4; r++) begin
            load_start();
            for (int w = 0; w < 5; w++) send_word(rand_inst(), 1'b1);
            load_end();
            have_if = 0; have_ex = 0;
            for (int c = 0; c < 42; c++) begin
                @(negedge CLK);
                if (have_ex) begin
                    checks++;
                    if (ex_bubble !== ex_bub || inst_index !== ex_inst[25:0] ||
                        pc_out !== N'(ex_pc) || pc1_out !== N'(ex_pc1))
                        $display("FAIL rnd_pass got=%b/%h/%0d/%0d want=%b/%h/%0d/%0d", ex_bubble,
                                 inst_index, pc_out, pc1_out, ex_bub, ex_inst[25:0], ex_pc, ex_pc1);
                    else passed++;
                    checks++;
                    if ({RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART, Branch} !==
                        (ex_bub ? 7'd0 : {e.rw, e.mw, e.mr, e.u2r, e.r2u, e.br}))
                        $display("FAIL rnd_ctrl inst=%h got=%b want=%b", ex_inst,
                                 {RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART, Branch},
                                 ex_bub ? 7'd0 : {e.rw, e.mw, e.mr, e.u2r, e.r2u, e.br});
                    else passed++;
                    if (!ex_bub) begin
                        checks++;
                        if ((e.alu_c && alu_result !== e.alu) || register_data !== e.rdat ||
                            (e.rw && (rdist !== e.rdist || MemtoReg !== e.mtr)) ||
                            (e.pc2_c && pc2_out !== e.pc2))
                            $display("FAIL rnd_data inst=%h got=%h/%h/%0d/%0d/%0d want=%h/%h/%0d/%0d/%0d",
                                     ex_inst, alu_result, register_data, rdist, MemtoReg, pc2_out,
                                     e.alu, e.rdat, e.rdist, e.mtr, e.pc2);
                        else passed++;
                    end
                end
                have_ex = 0;
                if (have_if) begin
                    checks++;
                    if (rs !== if_inst[25:21] || rt !== if_inst[20:16])
                        $display("FAIL rnd_rsrt got=%0d/%0d want=%0d/%0d", rs, rt,
                                 if_inst[25:21], if_inst[20:16]);
                    else passed++;
                    a = $urandom;
                    if ($urandom_range(0, 3) == 0) a = {{16{a[3]}}, a[15:0]};
                    b = ($urandom_range(0, 2) == 0) ? a : $urandom;
                    op1 = a; op2 = b;
                    e = model(if_inst, a, b, if_pc1);
                    ex_bub = if_bub; ex_inst = if_inst; ex_pc = if_pc; ex_pc1 = if_pc1;
                    have_ex = 1;
                end
                have_if = 0;
                if (c < 40) begin
                    pc = $urandom_range(0, 3);
                    if_pc1 = $urandom_range(0, 3);
                    if_bub = ($urandom_range(0, 7) == 0);
                    pc_in = N'(pc); pc1_in = N'(if_pc1); flush = if_bub;
                    if_inst = mm[pc]; if_pc = pc;
                    have_if = 1;
                end else begin
                    flush = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_addi();
        test_add();
        test_branch();
        test_jal();
        test_slt_flush_bad();
        test_load_edges();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
